// File: rtl/mem_bus_pkg.sv
// Shared widths, FSM state encoding and address helper for the line-to-burst adapter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_bus_pkg;

   localparam int LINE_BITS = 512;
   localparam int BEAT_BITS = 64;
   localparam int BEATS     = LINE_BITS / BEAT_BITS;
   localparam int CNT_BITS  = $clog2(BEATS);
   localparam int OFS_BITS  = $clog2(LINE_BITS / 8);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WDATA,
      RDATA,
      DONE
   } state_e;

   // Clears the byte offset inside a line so the bus only ever sees line addresses.
   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:OFS_BITS], {OFS_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line register viewed as BEATS beats, with a beat counter selecting the active beat.
// Latency: load/beat writes land on the next clock; the beat read mux is combinational.
// Backpressure: none; the caller only strobes beat_wr/beat_adv on accepted beats.
module line_beat_buffer
   import mem_bus_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load_en,
   input  logic [LINE_BITS-1:0] load_line,
   input  logic                 cnt_clr,
   input  logic                 beat_wr,
   input  logic [BEAT_BITS-1:0] beat_wdat,
   input  logic                 beat_adv,
   output logic [BEAT_BITS-1:0] beat_rdat,
   output logic [LINE_BITS-1:0] line,
   output logic [CNT_BITS-1:0]  cnt
);

   logic [BEATS-1:0][BEAT_BITS-1:0] line_q, line_d;
   logic [CNT_BITS-1:0]             cnt_q, cnt_d;

   // Next line contents and beat pointer; a beat write also advances the pointer.
   always_comb begin
      line_d = line_q;
      cnt_d  = cnt_q;
      if (load_en) begin
         line_d = load_line;
      end
      if (beat_wr) begin
         line_d[cnt_q] = beat_wdat;
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (beat_wr || beat_adv) begin
         cnt_d = cnt_q + CNT_BITS'(1);
      end
   end

   // Line and counter state, cleared by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_q <= '0;
         cnt_q  <= '0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
      end
   end

   assign beat_rdat = line_q[cnt_q];
   assign line      = line_q;
   assign cnt       = cnt_q;

endmodule

// File: rtl/mem_burst_adapter.sv
// Turns one cache line request into a bus command plus BEATS data beats, reassembling reads.
// Latency: 11 cycles enable-to-mem_ready with an always-ready bus (IDLE, CMD, 8 beats, DONE).
// Backpressure: cmd/wdata stall on ready low, reads accept rvalid always; a watchdog aborts stalls.
module mem_burst_adapter
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [31:0]          mem_address,
   input  logic [LINE_BITS-1:0] mem_write_data,
   input  logic                 mem_read_enable,
   input  logic                 mem_write_enable,
   output logic [LINE_BITS-1:0] mem_read_data,
   output logic                 mem_ready,
   output logic                 mem_error,
   output logic                 bus_cmd_valid,
   input  logic                 bus_cmd_ready,
   output logic                 bus_cmd_write,
   output logic [31:0]          bus_cmd_addr,
   output logic [BEAT_BITS-1:0] bus_wdata,
   output logic                 bus_wvalid,
   input  logic                 bus_wready,
   input  logic [BEAT_BITS-1:0] bus_rdata,
   input  logic                 bus_rvalid
);

   localparam int                  WD_BITS   = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_BITS-1:0]  WD_LAST   = WD_BITS'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

   state_e               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic                 is_write_q, is_write_d;
   logic                 err_q, err_d;
   logic                 skip_q, skip_d;
   logic [WD_BITS-1:0]   wd_q, wd_d;
   logic [LINE_BITS-1:0] rd_line_q, rd_line_d;

   logic                 buf_load, buf_clr, buf_wr, buf_adv;
   logic [BEAT_BITS-1:0] buf_beat;
   logic [LINE_BITS-1:0] buf_line;
   logic [CNT_BITS-1:0]  buf_cnt;

   line_beat_buffer u_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_en   (buf_load),
      .load_line (mem_write_data),
      .cnt_clr   (buf_clr),
      .beat_wr   (buf_wr),
      .beat_wdat (bus_rdata),
      .beat_adv  (buf_adv),
      .beat_rdat (buf_beat),
      .line      (buf_line),
      .cnt       (buf_cnt)
   );

   // FSM next state, handshakes, watchdog and all outputs; defaults keep outputs low.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      is_write_d    = is_write_q;
      err_d         = err_q;
      wd_d          = wd_q;
      rd_line_d     = rd_line_q;
      skip_d        = (state_q == DONE);
      buf_load      = 1'b0;
      buf_clr       = 1'b0;
      buf_wr        = 1'b0;
      buf_adv       = 1'b0;
      bus_cmd_valid = 1'b0;
      bus_cmd_write = 1'b0;
      bus_cmd_addr  = '0;
      bus_wvalid    = 1'b0;
      bus_wdata     = '0;
      mem_ready     = 1'b0;
      mem_error     = 1'b0;
      mem_read_data = rd_line_q;
      unique case (state_q)
         IDLE: begin
            // The cycle right after DONE is skipped so a lingering enable is not re-issued.
            if (!skip_q && (mem_write_enable || mem_read_enable)) begin
               addr_d     = line_align(mem_address);
               is_write_d = mem_write_enable;
               buf_load   = mem_write_enable;
               err_d      = 1'b0;
               wd_d       = '0;
               state_d    = CMD;
            end
         end
         CMD: begin
            bus_cmd_valid = 1'b1;
            bus_cmd_write = is_write_q;
            bus_cmd_addr  = addr_q;
            if (bus_cmd_ready) begin
               wd_d    = '0;
               buf_clr = 1'b1;
               state_d = is_write_q ? WDATA : RDATA;
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               wd_d = wd_q + WD_BITS'(1);
            end
         end
         WDATA: begin
            bus_wvalid = 1'b1;
            bus_wdata  = buf_beat;
            if (bus_wready) begin
               wd_d    = '0;
               buf_adv = 1'b1;
               if (buf_cnt == LAST_BEAT) begin
                  state_d = DONE;
               end
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               buf_clr = 1'b1;
               state_d = DONE;
            end else begin
               wd_d = wd_q + WD_BITS'(1);
            end
         end
         RDATA: begin
            if (bus_rvalid) begin
               wd_d   = '0;
               buf_wr = 1'b1;
               if (buf_cnt == LAST_BEAT) begin
                  state_d = DONE;
               end
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               buf_clr = 1'b1;
               state_d = DONE;
            end else begin
               wd_d = wd_q + WD_BITS'(1);
            end
         end
         DONE: begin
            mem_ready = 1'b1;
            mem_error = err_q;
            // Only reads (complete or aborted) replace the held line; writes leave it alone.
            if (!is_write_q) begin
               mem_read_data = buf_line;
               rd_line_d     = buf_line;
            end
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and held read-line registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         is_write_q <= 1'b0;
         err_q      <= 1'b0;
         skip_q     <= 1'b0;
         wd_q       <= '0;
         rd_line_q  <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         is_write_q <= is_write_d;
         err_q      <= err_d;
         skip_q     <= skip_d;
         wd_q       <= wd_d;
         rd_line_q  <= rd_line_d;
      end
   end

endmodule

// File: tb/tb_mem_burst_adapter.sv
// Bench for mem_burst_adapter: table-driven directed transactions, corner sequences, random traffic.
// Latency: checks the 11-cycle always-ready latency and the post-DONE idle gap.
// Backpressure: drives cmd_ready/wready/rvalid always-on, toggling, random or stuck low.
module tb_mem_burst_adapter;

   logic         clk;
   logic         reset_n;
   logic [31:0]  mem_address;
   logic [511:0] mem_write_data;
   logic         mem_read_enable;
   logic         mem_write_enable;
   logic [511:0] mem_read_data;
   logic         mem_ready;
   logic         mem_error;
   logic         bus_cmd_valid;
   logic         bus_cmd_ready;
   logic         bus_cmd_write;
   logic [31:0]  bus_cmd_addr;
   logic [63:0]  bus_wdata;
   logic         bus_wvalid;
   logic         bus_wready;
   logic [63:0]  bus_rdata;
   logic         bus_rvalid;

   mem_burst_adapter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_read_data    (mem_read_data),
      .mem_ready        (mem_ready),
      .mem_error        (mem_error),
      .bus_cmd_valid    (bus_cmd_valid),
      .bus_cmd_ready    (bus_cmd_ready),
      .bus_cmd_write    (bus_cmd_write),
      .bus_cmd_addr     (bus_cmd_addr),
      .bus_wdata        (bus_wdata),
      .bus_wvalid       (bus_wvalid),
      .bus_wready       (bus_wready),
      .bus_rdata        (bus_rdata),
      .bus_rvalid       (bus_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests, n_fail, cyc, n_ready, n_cmdv, n_spur, ready_wb, rd_left, rd_idx;
   int cmd_mode, wmode, rv_mode;
   int n, r0, c0, cv0, rq0, rs0;
   bit auto_drop, stray, prev_cmdv;
   logic         last_err;
   logic [511:0] rd_src, last_rdata, last_read, last_line_reg, pat1, wd;
   logic [31:0]  a;
   bit           wr, rd;
   logic [32:0]  cmd_log[$];
   logic [63:0]  wbeats[$];
   int           ready_q[$];
   int           rise_q[$];
   logic [511:0] bus_mem[logic [31:0]];
   logic [511:0] ref_mem[logic [31:0]];

   typedef struct {
      bit          wr;
      bit          rd;
      logic [31:0] addr;
      logic [63:0] wbase;
      int          wmode;
      int          bmode;
      logic        exp_write;
      logic [31:0] exp_addr;
      int          exp_lat;
   } vec_t;
   vec_t vecs[6];

   function automatic logic [511:0] beat_pat(input logic [63:0] base, input logic [63:0] step);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + step * 64'(k);
      return l;
   endfunction

   function automatic logic [511:0] init_line(input logic [31:0] addr);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = {addr, 32'(k) ^ 32'h5A5A_0000};
      return l;
   endfunction

   function automatic logic [511:0] bus_get(input logic [31:0] addr);
      return bus_mem.exists(addr) ? bus_mem[addr] : init_line(addr);
   endfunction

   function automatic logic [511:0] ref_get(input logic [31:0] addr);
      return ref_mem.exists(addr) ? ref_mem[addr] : init_line(addr);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkw(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: log what handshakes at the coming edge, then drive the bus model's next inputs.
   task automatic tick();
      bit rdy;
      rdy = mem_ready;
      if (bus_cmd_valid && !prev_cmdv) rise_q.push_back(cyc);
      prev_cmdv = bus_cmd_valid;
      if (bus_cmd_valid) n_cmdv++;
      if (mem_error && !mem_ready) n_spur++;
      if (bus_cmd_valid && bus_cmd_ready) begin
         cmd_log.push_back({bus_cmd_write, bus_cmd_addr});
         if (!bus_cmd_write) begin
            rd_src  = bus_get(bus_cmd_addr);
            rd_left = 8;
            rd_idx  = 0;
         end
      end
      if (bus_wvalid && bus_wready) wbeats.push_back(bus_wdata);
      if (bus_rvalid && !stray && rd_left > 0) begin
         rd_idx++;
         rd_left--;
      end
      if (mem_ready) begin
         n_ready++;
         ready_q.push_back(cyc);
         last_rdata = mem_read_data;
         last_err   = mem_error;
         ready_wb   = wbeats.size();
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rdy && auto_drop) begin
         mem_read_enable  = 1'b0;
         mem_write_enable = 1'b0;
      end
      bus_cmd_ready = (cmd_mode == 0) ? 1'b1 : (cmd_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      bus_wready    = (wmode == 0) ? 1'b1 : (wmode == 1) ? ~bus_wready : ($urandom_range(0, 2) != 0);
      bus_rvalid    = stray || (rd_left > 0 && (rv_mode == 0 || $urandom_range(0, 2) != 0));
      bus_rdata     = stray ? {$urandom, $urandom} : (rd_left > 0 ? rd_src[rd_idx*64 +: 64] : 64'd0);
   endtask

   // Full cache-side transaction with every check that applies to a normal completion.
   task automatic do_txn(input bit t_wr, input bit t_rd, input logic [31:0] t_a, input logic [511:0] t_wd,
                         input logic exp_w, input logic [31:0] exp_a, input int exp_lat, input string tag);
      logic [511:0] el, got;
      int tr0, tc0, tn;
      el = exp_w ? t_wd : ref_get(exp_a);
      cmd_log.delete();
      wbeats.delete();
      tr0 = n_ready;
      tc0 = cyc;
      mem_address      = t_a;
      mem_write_data   = t_wd;
      mem_write_enable = t_wr;
      mem_read_enable  = t_rd;
      tn = 0;
      while (n_ready == tr0 && tn < 400) begin
         tick();
         tn++;
      end
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check32({tag, "/ready_count"}, n_ready - tr0, 1);
      check32({tag, "/cmd_count"}, cmd_log.size(), 1);
      if (cmd_log.size() > 0) begin
         check32({tag, "/cmd_addr"}, cmd_log[0][31:0], exp_a);
         check32({tag, "/cmd_write"}, 32'(cmd_log[0][32]), 32'(exp_w));
      end
      if (n_ready > tr0) begin
         check32({tag, "/error"}, 32'(last_err), 0);
         if (exp_lat > 0) check32({tag, "/latency"}, ready_q[$] - tc0 + 1, exp_lat);
      end
      if (exp_w) begin
         check32({tag, "/beats"}, wbeats.size(), 8);
         check32({tag, "/beats_before_ready"}, ready_wb, 8);
         got = '0;
         for (int i = 0; i < 8 && i < wbeats.size(); i++) got[i*64 +: 64] = wbeats[i];
         checkw({tag, "/wdata"}, got, t_wd);
         bus_mem[exp_a] = got;
         ref_mem[exp_a] = t_wd;
      end else begin
         checkw({tag, "/rdata"}, last_rdata, el);
         last_read = el;
      end
      last_line_reg = el;
      checkw({tag, "/rdata_hold"}, mem_read_data, last_read);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; n_ready = 0; n_cmdv = 0; n_spur = 0;
      ready_wb = 0; rd_left = 0; rd_idx = 0;
      cmd_mode = 0; wmode = 0; rv_mode = 0;
      auto_drop = 1'b1; stray = 1'b0; prev_cmdv = 1'b0;
      last_err = 1'b0; rd_src = '0; last_rdata = '0; last_read = '0; last_line_reg = '0;
      reset_n = 1'b0;
      mem_address = '0; mem_write_data = '0; mem_read_enable = 1'b0; mem_write_enable = 1'b0;
      bus_cmd_ready = 1'b1; bus_wready = 1'b1; bus_rdata = '0; bus_rvalid = 1'b0;

      vecs[0] = '{1'b0, 1'b1, 32'h0000_1234, 64'h0,           0, 0, 1'b0, 32'h0000_1200, 11};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_1000, 64'hA0,          1, 0, 1'b1, 32'h0000_1000, 0};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_5678, 64'hB0_0000_0000, 0, 0, 1'b1, 32'h0000_5640, 11};
      vecs[3] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 64'h0,           0, 0, 1'b0, 32'hFFFF_FFC0, 11};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_5640, 64'h0,           0, 0, 1'b0, 32'h0000_5640, 11};
      vecs[5] = '{1'b1, 1'b0, 32'h8000_003F, 64'hC0,          2, 1, 1'b1, 32'h8000_0000, 0};

      pat1 = beat_pat(64'h0, 64'h1111_1111_1111_1111);
      bus_mem[32'h0000_1200] = pat1;
      ref_mem[32'h0000_1200] = pat1;

      // Reset state
      repeat (2) tick();
      check32("reset/mem_ready", 32'(mem_ready), 0);
      check32("reset/mem_error", 32'(mem_error), 0);
      check32("reset/cmd_valid", 32'(bus_cmd_valid), 0);
      check32("reset/cmd_write", 32'(bus_cmd_write), 0);
      check32("reset/cmd_addr", bus_cmd_addr, 0);
      check32("reset/wvalid", 32'(bus_wvalid), 0);
      check32("reset/wdata_lo", bus_wdata[31:0], 0);
      checkw("reset/read_data", mem_read_data, '0);
      reset_n = 1'b1;
      tick();

      // Directed table: read latency, toggling wready, both enables, alignment, read-back
      for (int v = 0; v < 6; v++) begin
         wmode    = vecs[v].wmode;
         cmd_mode = vecs[v].bmode;
         rv_mode  = vecs[v].bmode;
         do_txn(vecs[v].wr, vecs[v].rd, vecs[v].addr, beat_pat(vecs[v].wbase, 64'h1),
                vecs[v].exp_write, vecs[v].exp_addr, vecs[v].exp_lat, $sformatf("vec%0d", v));
      end
      wmode = 0; cmd_mode = 0; rv_mode = 0;
      tick();

      // Back-to-back reads with the enable held: second command only after the idle cycle
      auto_drop = 1'b0;
      rq0 = ready_q.size(); rs0 = rise_q.size(); r0 = n_ready;
      mem_address = 32'h0000_4444; mem_read_enable = 1'b1;
      n = 0;
      while (n_ready - r0 < 2 && n < 100) begin
         tick();
         n++;
      end
      mem_read_enable = 1'b0; auto_drop = 1'b1;
      repeat (4) tick();
      check32("b2b/ready_count", n_ready - r0, 2);
      check32("b2b/cmd_count", rise_q.size() - rs0, 2);
      if (rise_q.size() - rs0 >= 2 && ready_q.size() - rq0 >= 1)
         check32("b2b/gap", rise_q[rs0+1] - ready_q[rq0], 3);
      checkw("b2b/rdata", last_rdata, ref_get(32'h0000_4440));
      last_read = ref_get(32'h0000_4440);
      last_line_reg = last_read;

      // Stray rvalid while idle
      r0 = n_ready; rs0 = rise_q.size();
      stray = 1'b1;
      repeat (4) tick();
      stray = 1'b0;
      tick();
      check32("stray/no_ready", n_ready - r0, 0);
      check32("stray/no_cmd", rise_q.size() - rs0, 0);
      checkw("stray/rdata_hold", mem_read_data, last_read);

      // Command never accepted: watchdog aborts with error and partial (untouched) line
      cmd_mode = 2; bus_cmd_ready = 1'b0;
      cv0 = n_cmdv; r0 = n_ready; cmd_log.delete();
      mem_address = 32'h0000_2000; mem_read_enable = 1'b1;
      n = 0;
      while (n_ready == r0 && n < 1200) begin
         tick();
         n++;
      end
      cmd_mode = 0;
      tick(); tick();
      check32("timeout/ready_count", n_ready - r0, 1);
      check32("timeout/error", 32'(last_err), 1);
      check32("timeout/cmd_cycles", n_cmdv - cv0, 1024);
      check32("timeout/no_accept", cmd_log.size(), 0);
      checkw("timeout/partial_line", last_rdata, last_line_reg);
      last_read = last_line_reg;
      do_txn(1'b0, 1'b1, 32'h0000_2000, '0, 1'b0, 32'h0000_2000, 11, "timeout/next_read");

      // Reset during beat 4 of a read
      r0 = n_ready;
      mem_address = 32'h0000_3000; mem_read_enable = 1'b1;
      n = 0;
      while (!(rd_left > 0 && rd_idx == 4) && n < 50) begin
         tick();
         n++;
      end
      check32("rst_mid/reached_beat4", 32'(rd_idx), 4);
      reset_n = 1'b0;
      mem_read_enable = 1'b0; rd_left = 0; bus_rvalid = 1'b0;
      #1;
      check32("rst_mid/mem_ready", 32'(mem_ready), 0);
      check32("rst_mid/cmd_valid", 32'(bus_cmd_valid), 0);
      check32("rst_mid/wvalid", 32'(bus_wvalid), 0);
      checkw("rst_mid/read_data", mem_read_data, '0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick(); tick();
      check32("rst_mid/no_ready", n_ready - r0, 0);
      last_read = '0; last_line_reg = '0;
      do_txn(1'b0, 1'b1, 32'h0000_3010, '0, 1'b0, 32'h0000_3000, 11, "rst_mid/next_read");

      // Random traffic over a few lines with random backpressure
      for (int t = 0; t < 30; t++) begin
         a  = 32'h0001_0000 + 32'($urandom_range(0, 3)) * 32'd64 + 32'($urandom_range(0, 63));
         wr = ($urandom_range(0, 1) == 1);
         rd = !wr || ($urandom_range(0, 3) == 0);
         for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom;
         cmd_mode = $urandom_range(0, 1);
         rv_mode  = $urandom_range(0, 1);
         wmode    = $urandom_range(0, 2);
         do_txn(wr, rd, a, wd, wr, {a[31:6], 6'b0}, 0, $sformatf("rand%0d", t));
      end

      check32("error_only_with_ready", n_spur, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
